// File: rtl/cicero_seq_pkg.sv
// Shared definitions for the CICERO command sequencer.
// Contents:
//   - opcode values carried in command[3:0]
//   - sequencer state encoding, reported in status[3:0]
//   - bit positions of the status flags
package cicero_seq_pkg;

   localparam logic [3:0] OpNop   = 4'd0;
   localparam logic [3:0] OpWrite = 4'd1;
   localparam logic [3:0] OpRead  = 4'd2;
   localparam logic [3:0] OpStart = 4'd3;
   localparam logic [3:0] OpReset = 4'd4;
   localparam logic [3:0] OpClr   = 4'd5;

   typedef enum logic [3:0] {
      StIdle     = 4'd0,
      StDecode   = 4'd1,
      StMemWr    = 4'd2,
      StMemRd    = 4'd3,
      StEngStart = 4'd4,
      StEngWait  = 4'd5,
      StEngRst   = 4'd6,
      StDone     = 4'd7
   } state_e;

   localparam int unsigned StatBusy    = 4;
   localparam int unsigned StatDone    = 5;
   localparam int unsigned StatError   = 6;
   localparam int unsigned StatTimeout = 7;
   localparam int unsigned StatMatch   = 8;

   // Length of the engine soft-reset pulse in cycles.
   localparam int unsigned EngRstCycles = 4;

endpackage

// File: rtl/cicero_cmd_sync.sv
// Brings the JTAG command register into the system clock domain and detects new commands.
// Ports:
//   clk_i, rst_ni  system clock, asynchronous active-low reset
//   cmd_i          raw command register (tck domain), [31] is the host toggle
//   cmd_valid_o    one-cycle pulse: a new, stable command is present
//   cmd_op_o       synchronized opcode, valid with cmd_valid_o
module cicero_cmd_sync (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] cmd_i,
   output logic        cmd_valid_o,
   output logic [3:0]  cmd_op_o
);

   logic [31:0] sync1_q, sync2_q, prev_q;
   logic        acc_q, acc_d;

   // A multi-bit word may be caught mid-change; requiring two equal consecutive
   // synchronized samples rejects a torn capture.
   assign cmd_valid_o = (sync2_q[31] != acc_q) && (sync2_q == prev_q);
   assign cmd_op_o    = sync2_q[3:0];

   // The toggle is marked accepted on every detection, executed or not.
   always_comb begin
      acc_d = acc_q;
      if (cmd_valid_o) acc_d = sync2_q[31];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         acc_q   <= 1'b0;
      end else begin
         sync1_q <= cmd_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         acc_q   <= acc_d;
      end
   end

endmodule

// File: rtl/cicero_cmd_sequencer.sv
// Executes host commands from the virtual JTAG register set: instruction-memory
// single-word write/read, engine start and engine soft reset.
// Ports:
//   clk, rst_n                       system clock, asynchronous active-low reset
//   command/address/pointers/data_in JTAG-side command operands (inputs)
//   status, data_out                 polled by JTAG
//   mem_*                            instruction-memory port
//   eng_*                            CICERO engine control / result
// Optional feature: define CICERO_SEQ_TIMEOUT_EN to enable the engine-run watchdog
// (TIMEOUT_CYCLES); otherwise ENG_WAIT waits indefinitely and status[7] stays 0.
module cicero_cmd_sequencer
   import cicero_seq_pkg::*;
#(
   parameter int unsigned MEM_AW         = 9,
   parameter int unsigned DATA_W         = 64,
   parameter int unsigned CC_W           = 32,
   parameter int unsigned MEM_RD_LAT     = 1,
   parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       command,
   input  logic [31:0]       address,
   input  logic [CC_W-1:0]   start_cc_pointer,
   input  logic [CC_W-1:0]   end_cc_pointer,
   input  logic [DATA_W-1:0] data_in,
   output logic [31:0]       status,
   output logic [DATA_W-1:0] data_out,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              eng_start,
   output logic [CC_W-1:0]   eng_start_cc,
   output logic [CC_W-1:0]   eng_end_cc,
   output logic              eng_rst,
   input  logic              eng_done,
   input  logic              eng_accept
);

   state_e            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [3:0]        op_q, op_d;
   logic [MEM_AW-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [CC_W-1:0]   scc_q, scc_d, ecc_q, ecc_d;
   logic              busy_q, busy_d, done_q, done_d, error_q, error_d;
   logic              tmo_q, tmo_d, match_q, match_d;
   logic [15:0]       count_q, count_d;
   logic              cmd_valid;
   logic [3:0]        cmd_op;
   logic              tmo_hit;
   logic [31-MEM_AW:0] unused_addr;

   assign unused_addr = address[31:MEM_AW];

   cicero_cmd_sync u_sync (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .cmd_i      (command),
      .cmd_valid_o(cmd_valid),
      .cmd_op_o   (cmd_op)
   );

`ifdef CICERO_SEQ_TIMEOUT_EN
   localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TmoW-1:0] wait_q, wait_d;

   assign wait_d  = (state_q == StEngWait) ? wait_q + 1'b1 : '0;
   assign tmo_hit = (state_q == StEngWait) && (wait_q == TmoW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wait_q <= '0;
      else        wait_q <= wait_d;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      scc_d   = scc_q;
      ecc_d   = ecc_q;
      busy_d  = busy_q;
      done_d  = done_q;
      error_d = error_q;
      tmo_d   = tmo_q;
      match_d = match_q;
      count_d = count_q;

      case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               // Operands are stable before the toggle flips, so capture them raw.
               state_d = StDecode;
               op_d    = cmd_op;
               addr_d  = address[MEM_AW-1:0];
               wdata_d = data_in;
               scc_d   = start_cc_pointer;
               ecc_d   = end_cc_pointer;
               busy_d  = 1'b1;
               done_d  = 1'b0;
            end
         end
         StDecode: begin
            case (op_q)
               OpNop:   state_d = StDone;
               OpWrite: state_d = StMemWr;
               OpRead:  state_d = StMemRd;
               OpStart: state_d = StEngStart;
               OpReset: state_d = StEngRst;
               OpClr: begin
                  done_d  = 1'b0;
                  error_d = 1'b0;
                  tmo_d   = 1'b0;
                  match_d = 1'b0;
                  busy_d  = 1'b0;
                  state_d = StIdle;
               end
               default: begin
                  error_d = 1'b1;
                  state_d = StDone;
               end
            endcase
         end
         StMemWr: state_d = StDone;
         StMemRd: begin
            if (cnt_q == 3'(MEM_RD_LAT)) begin
               rdata_d = mem_rdata;
               state_d = StDone;
            end
         end
         StEngStart: state_d = StEngWait;
         StEngWait: begin
            if (eng_done) begin
               match_d = eng_accept;
               state_d = StDone;
            end else if (tmo_hit) begin
               tmo_d   = 1'b1;
               error_d = 1'b1;
               state_d = StEngRst;
            end
         end
         StEngRst: begin
            if (cnt_q == 3'(EngRstCycles - 1)) state_d = StDone;
         end
         StDone: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            count_d = count_q + 16'd1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // A toggle arriving mid-operation is consumed but never executed.
      if (cmd_valid && (state_q != StIdle)) error_d = 1'b1;

      cnt_d = (state_d == state_q) ? cnt_q + 3'd1 : 3'd0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         op_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         scc_q   <= '0;
         ecc_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         tmo_q   <= 1'b0;
         match_q <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         scc_q   <= scc_d;
         ecc_q   <= ecc_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         error_q <= error_d;
         tmo_q   <= tmo_d;
         match_q <= match_d;
         count_q <= count_d;
      end
   end

   assign mem_addr     = addr_q;
   assign mem_wdata    = wdata_q;
   assign mem_we       = (state_q == StMemWr);
   assign mem_re       = (state_q == StMemRd) && (cnt_q == 3'd0);
   assign data_out     = rdata_q;
   assign eng_start    = (state_q == StEngStart);
   assign eng_start_cc = scc_q;
   assign eng_end_cc   = ecc_q;
   assign eng_rst      = (state_q == StEngRst);

   always_comb begin
      status                = '0;
      status[3:0]           = state_q;
      status[StatBusy]      = busy_q;
      status[StatDone]      = done_q;
      status[StatError]     = error_q;
      status[StatTimeout]   = tmo_q;
      status[StatMatch]     = match_q;
      status[31:16]         = count_q;
   end

endmodule

// File: doc/cicero_cmd_sequencer.md
Name: cicero_cmd_sequencer

Overview:
- Executes host commands written over the virtual JTAG register set in the system clock domain.
- Command-side inputs (command, address, start_cc_pointer, end_cc_pointer, data_in) come from the JTAG adapter. status and data_out are returned to it for polling.
- Sequences single-word writes and reads of the CICERO instruction memory, and engine start and soft-reset, reporting progress and result in status.

Parameters:
- MEM_AW, 9: instruction-memory word-address width; address[MEM_AW-1:0] is used.
- DATA_W, 64: memory data width; data_in and data_out are DATA_W bits.
- CC_W, 32: width of the start/end character pointers.
- MEM_RD_LAT, 1: cycles from mem_re to a valid mem_rdata (1..4).
- TIMEOUT_CYCLES, 1048576: engine-run watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- command  in  32  JTAG command register (tck domain): [31] toggle, [3:0] opcode
- address  in  32  memory word address
- start_cc_pointer  in  CC_W  engine start pointer
- end_cc_pointer  in  CC_W  engine end pointer
- data_in  in  DATA_W  memory write data
- status  out  32  status word to JTAG
- data_out  out  DATA_W  memory read result to JTAG
- mem_addr  out  MEM_AW  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_we  out  1  memory write strobe
- mem_re  out  1  memory read strobe
- mem_rdata  in  DATA_W  memory read data
- eng_start  out  1  one-cycle engine start pulse
- eng_start_cc  out  CC_W  start pointer, held during a run
- eng_end_cc  out  CC_W  end pointer, held during a run
- eng_rst  out  1  engine soft reset
- eng_done  in  1  engine finished (pulse)
- eng_accept  in  1  match result, valid with eng_done

Behaviour:
- **Reset values.**
  - All outputs are 0 at reset.
  - The state is IDLE and all internal captures are cleared.
  - Reset mid-operation aborts immediately; no further memory or engine strobes are issued.
- **Command capture and clock crossing.**
  - command passes through a 2-FF synchronizer. A sync_prev register holds the previous synchronized value.
  - A new command is detected when synchronized bit [31] differs from the last accepted toggle AND the synchronized command equals sync_prev, i.e. it is stable for 2 cycles.
  - The host guarantees that address, pointers and data_in are stable before it flips [31]. These are captured directly in the detection cycle, with no synchronizer.
- **State machine.** States: IDLE, DECODE, MEM_WR, MEM_RD, ENG_START, ENG_WAIT, ENG_RST, DONE.
  - IDLE → DECODE on command detection; the opcode and operands are latched and busy is set.
  - DECODE dispatches on opcode:
    - 0 NOP → DONE
    - 1 WRITE → MEM_WR
    - 2 READ → MEM_RD
    - 3 START → ENG_START
    - 4 RESET → ENG_RST
    - 5 CLR → clears done, error and the result bit, then → IDLE
    - other → error = 1, then DONE
  - MEM_WR: mem_we = 1 for exactly 1 cycle, with mem_addr and mem_wdata valid → DONE.
  - MEM_RD: mem_re = 1 for 1 cycle, then wait MEM_RD_LAT cycles. data_out is loaded from mem_rdata on the final cycle → DONE. data_out updates only in this state.
  - ENG_START: eng_start = 1 for 1 cycle, with eng_start_cc and eng_end_cc driven from the latched pointers → ENG_WAIT.
  - ENG_WAIT: on eng_done, latch eng_accept into status[8] → DONE. eng_done in any other state is ignored.
  - ENG_RST: eng_rst = 1 for 4 cycles → DONE.
  - DONE: done = 1, busy = 0, cmd_count += 1 (wraps 0xFFFF → 0) → IDLE.
- **Busy rule.** A new toggle detected while not in IDLE is not executed. It sets error = 1 and is still marked accepted, so it is not re-run later.
- **Status layout.**
  - [3:0] state encoding
  - [4] busy
  - [5] done
  - [6] error
  - [7] timeout
  - [8] match result
  - [15:9] 0
  - [31:16] cmd_count
- **Flag lifetime.**
  - done is sticky until the next accepted command or CLR.
  - error, timeout and the match result are sticky until CLR.

Optional Feature:
- Macro: CICERO_SEQ_TIMEOUT_EN.
- With the macro:
  - A counter runs in ENG_WAIT.
  - Reaching TIMEOUT_CYCLES sets timeout = 1 and error = 1, pulses eng_rst for 4 cycles, then → DONE.
- Without the macro: no counter, status[7] is tied to 0, and ENG_WAIT waits indefinitely.

Decomposition:
- Shared package cicero_seq_pkg holds:
  - the opcode localparams;
  - the state enum/encoding;
  - status bit-index constants.
- One natural sub-module: cicero_cmd_sync, the 2-FF synchronizer plus stable-toggle detector. It outputs a one-cycle cmd_valid.

Test Plan:
- Write then read:
  - Stimulus: address=5, data_in=0xDEADBEEF_01234567, command=0x8000_0001, then command=0x0000_0002.
  - Response: one mem_we with mem_addr=5. data_out=0xDEADBEEF_01234567. status[31:16]=2, [5]=1.
- Engine start:
  - Stimulus: pointers 0x10 and 0x40, command=0x8000_0003; eng_done plus eng_accept after 100 cycles.
  - Response: one eng_start with eng_start_cc=0x10 and eng_end_cc=0x40. busy=1 during the run. Then status[8]=1, [5]=1.
- Unknown opcode:
  - Stimulus: command=0x8000_000A.
  - Response: no memory or engine strobes; status[6]=1, [5]=1.
- Collision:
  - Stimulus: START without eng_done, then toggle [31] with a WRITE.
  - Response: no mem_we; error=1.
  - Then: eng_done returns the machine to IDLE, and CLR (opcode 5) clears [6] and [5].
- Reset during ENG_WAIT:
  - Stimulus: rst_n=0.
  - Response: all outputs 0 and state IDLE; a re-issued command runs normally.
- Timeout (CICERO_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=64):
  - Stimulus: START with no eng_done.
  - Response: after 64 cycles status[7]=1 and [6]=1, and eng_rst pulses for 4 cycles.
